// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_pkg
// Purpose  : Shared widths, FSM state codes and handshake constants for the
//            EX-stage sequential divider.
// Revision : 1.0
// ============================================================================
package div_seq_ctrl_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic c_DIV_START             = 1'b1;
    localparam logic c_DIV_STOP              = 1'b0;
    localparam logic c_DIV_RESULT_READY      = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_if
// Purpose  : EX <-> divider handshake: operands and start/annul in, result,
//            ready and stall request out.
// Revision : 1.0
// ============================================================================
interface div_seq_ctrl_if #(
    parameter int DATA_W = div_seq_ctrl_pkg::DIV_DATA_W
) ();

    logic                  start_i;
    logic                  annul_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );

endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_step
// Purpose  : One radix-2 restoring divide iteration (purely combinational).
// Revision : 1.0
// ============================================================================
module div_seq_ctrl_step #(
    parameter int DATA_W = 32
) (
    input  wire logic [2*DATA_W:0]  i_work,
    input  wire logic [DATA_W-1:0]  i_divisor,
    output logic      [2*DATA_W:0]  o_work
);

    logic [DATA_W:0] w_diff;

    // The partial remainder is always below 2*divisor, so bit DATA_W of the
    // difference is a reliable sign bit.
    assign w_diff = i_work[2*DATA_W:DATA_W] - {1'b0, i_divisor};

    assign o_work = w_diff[DATA_W]
                  ? {i_work[2*DATA_W-1:0], 1'b0}
                  : {w_diff[DATA_W-1:0], i_work[DATA_W-1:0], 1'b1};

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl
// Purpose  : Multi-cycle DIV/DIVU sequencer: restoring divide over DATA_W
//            iterations with stall request, sign fix-up and annul.
// Revision : 1.0
// ============================================================================
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    div_seq_ctrl_if.slave   div_if
);

    div_state_t            r_state,   w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
    logic [2*DATA_W:0]     r_work,    w_work_nxt;
    logic [2*DATA_W:0]     w_work_step;
    logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
    logic                  r_sign1,   w_sign1_nxt;
    logic                  r_sign2,   w_sign2_nxt;
    logic [2*DATA_W-1:0]   r_result,  w_result_nxt;
    logic                  r_ready,   w_ready_nxt;
    logic                  w_stall;
    logic                  w_go;
    logic                  w_neg1;
    logic                  w_neg2;
    logic [DATA_W-1:0]     w_abs1;
    logic [DATA_W-1:0]     w_abs2;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

    assign w_go   = (div_if.start_i == c_DIV_START) && !div_if.annul_i;
    assign w_neg1 = div_if.signed_i && div_if.opdata1_i[DATA_W-1];
    assign w_neg2 = div_if.signed_i && div_if.opdata2_i[DATA_W-1];
    assign w_abs1 = w_neg1 ? neg_w(div_if.opdata1_i) : div_if.opdata1_i;
    assign w_abs2 = w_neg2 ? neg_w(div_if.opdata2_i) : div_if.opdata2_i;

    // Sign bits were latched already qualified by signed_i.
    assign w_quot = (r_sign1 ^ r_sign2) ? neg_w(r_work[DATA_W-1:0])
                                        : r_work[DATA_W-1:0];
    assign w_rem  = r_sign1 ? neg_w(r_work[2*DATA_W:DATA_W+1])
                            : r_work[2*DATA_W:DATA_W+1];

    div_seq_ctrl_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_work_step)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_sign1_nxt   = r_sign1;
        w_sign2_nxt   = r_sign2;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;
        w_stall       = 1'b0;

        case (r_state)
            DIV_FREE: begin
                w_stall = w_go;
                if (w_go) begin
                    w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                    if (div_if.opdata2_i == '0) begin
                        w_state_nxt = DIV_BY_ZERO;
                    end else begin
                        w_state_nxt   = DIV_ON;
                        w_cnt_nxt     = '0;
                        w_sign1_nxt   = w_neg1;
                        w_sign2_nxt   = w_neg2;
                        w_divisor_nxt = w_abs2;
                        w_work_nxt    = {{DATA_W{1'b0}}, w_abs1, 1'b0};
                    end
                end
            end
            DIV_BY_ZERO: begin
                w_stall      = 1'b1;
                w_result_nxt = '0;
                if (div_if.annul_i) begin
                    w_state_nxt = DIV_FREE;
                    w_ready_nxt = c_DIV_RESULT_NOT_READY;
                end else begin
                    w_state_nxt = DIV_END;
                    w_ready_nxt = c_DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                w_stall = 1'b1;
                // Annul wins even on the completion cycle.
                if (div_if.annul_i) begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                end else if (r_cnt == CNT_W'(DATA_W)) begin
                    w_state_nxt  = DIV_END;
                    w_ready_nxt  = c_DIV_RESULT_READY;
                    w_result_nxt = {w_rem, w_quot};
                end else begin
                    w_work_nxt = w_work_step;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end
            end
            DIV_END: begin
                if (div_if.annul_i || (div_if.start_i == c_DIV_STOP)) begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = DIV_FREE;
                w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                w_result_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_result  <= '0;
            r_ready   <= c_DIV_RESULT_NOT_READY;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_sign1   <= w_sign1_nxt;
            r_sign2   <= w_sign2_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign div_if.result_o   = r_result;
    assign div_if.ready_o    = r_ready;
    assign div_if.stallreq_o = w_stall;

endmodule
`default_nettype wire
